// File: rtl/fifo_adapter_pkg.sv
// Shared constants and types for the single-port FIFO stream adapter.
// The output buffer depth is fixed; the arbiter reserves buffer space against it.
package fifo_adapter_pkg;

    localparam int unsigned WIDTH    = 32;
    localparam int unsigned OBUF_ELS = 2;

    typedef enum logic {
        PRIO_ENQ = 1'b0,
        PRIO_DEQ = 1'b1
    } prio_e;

endpackage

// File: rtl/fifo_adapter_obuf.sv
// Two-entry shift buffer holding FIFO read data for the consumer.
// Entry 0 is always the head; a same-cycle pop and push are both honoured.
module fifo_adapter_obuf
    import fifo_adapter_pkg::*;
#(
    parameter int unsigned width_p = WIDTH
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               push_i,
    input  logic [width_p-1:0] push_data_i,
    input  logic               pop_i,
    output logic [1:0]         count_o,
    output logic [width_p-1:0] head_o
);

    logic [width_p-1:0] mem_q [OBUF_ELS];
    logic [width_p-1:0] mem_d [OBUF_ELS];
    logic [1:0]         count_q;
    logic [1:0]         count_d;
    logic               do_pop;
    logic               do_push;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        do_push = 1'b0;
        if (do_pop) begin
            mem_d[0] = mem_q[1];
            count_d  = count_q - 2'd1;
        end
        // Push lands after the pop has shifted, so the write slot is the post-pop count.
        if (push_i && (count_d != 2'd2)) begin
            do_push             = 1'b1;
            mem_d[count_d[0]]   = push_data_i;
        end
        if (do_push) begin
            count_d = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/fifo_1rw_stream_adapter.sv
// Converts producer/consumer valid-ready streams into the one-op-per-cycle
// command interface of a single-port FIFO, buffering read data for the consumer.
module fifo_1rw_stream_adapter
    import fifo_adapter_pkg::*;
#(
    parameter int unsigned width_p = WIDTH
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               up_v_i,
    input  logic [width_p-1:0] up_data_i,
    output logic               up_ready_o,
    output logic               dn_v_o,
    output logic [width_p-1:0] dn_data_o,
    input  logic               dn_ready_i,
    output logic               fifo_v_o,
    output logic               fifo_enq_not_deq_o,
    output logic [width_p-1:0] fifo_data_o,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    input  logic [width_p-1:0] fifo_data_i
);

    localparam int unsigned obuf_els_p = OBUF_ELS;

    prio_e       prio_q;
    prio_e       prio_d;
    logic        inflight_q;
    logic        inflight_d;
    logic [1:0]  obuf_count;
    logic [2:0]  occupancy;
    logic        deq_ok;
    logic        enq_ok;
    logic        contended;
    logic        enq_fire;
    logic        deq_fire;
    logic        pop;

    // Count the outstanding read as occupied so its data always has a slot.
    assign occupancy = {1'b0, obuf_count} + {2'b00, inflight_q};
    assign deq_ok    = !fifo_empty_i && (occupancy < 3'(obuf_els_p));
    assign enq_ok    = !fifo_full_i;
    assign contended = enq_ok && deq_ok;

    assign up_ready_o = reset_ni && enq_ok && !(deq_ok && (prio_q == PRIO_DEQ));
    assign enq_fire   = up_v_i && up_ready_o;
    assign deq_fire   = reset_ni && deq_ok && !enq_fire;

    assign fifo_v_o           = enq_fire || deq_fire;
    assign fifo_enq_not_deq_o = enq_fire;
    assign fifo_data_o        = up_data_i;

    always_comb begin
        inflight_d = deq_fire;
        prio_d     = prio_q;
        if (contended) begin
            prio_d = (prio_q == PRIO_ENQ) ? PRIO_DEQ : PRIO_ENQ;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            prio_q     <= PRIO_ENQ;
            inflight_q <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            inflight_q <= inflight_d;
        end
    end

    assign dn_v_o = (obuf_count != 2'd0);
    assign pop    = dn_v_o && dn_ready_i;

    fifo_adapter_obuf #(
        .width_p (width_p)
    ) u_obuf (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (pop),
        .count_o     (obuf_count),
        .head_o      (dn_data_o)
    );

endmodule

// File: tb/tb_fifo_1rw_stream_adapter.sv
// Bench for fifo_1rw_stream_adapter: a single-port FIFO model plus a queue-based
// reference of accepted words and the arbitration rules, checked every cycle.
module tb_fifo_1rw_stream_adapter;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        up_v_i = 1'b0;
    logic [31:0] up_data_i = '0;
    logic        up_ready_o;
    logic        dn_v_o;
    logic [31:0] dn_data_o;
    logic        dn_ready_i = 1'b0;
    logic        fifo_v_o;
    logic        fifo_enq_not_deq_o;
    logic [31:0] fifo_data_o;
    logic        fifo_full_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;

    int n_vec = 0;
    int n_err = 0;
    int n_deliv = 0;

    always #5 clk = ~clk;

    fifo_1rw_stream_adapter dut (
        .clk_i              (clk),
        .reset_ni           (reset_ni),
        .up_v_i             (up_v_i),
        .up_data_i          (up_data_i),
        .up_ready_o         (up_ready_o),
        .dn_v_o             (dn_v_o),
        .dn_data_o          (dn_data_o),
        .dn_ready_i         (dn_ready_i),
        .fifo_v_o           (fifo_v_o),
        .fifo_enq_not_deq_o (fifo_enq_not_deq_o),
        .fifo_data_o        (fifo_data_o),
        .fifo_full_i        (fifo_full_i),
        .fifo_empty_i       (fifo_empty_i),
        .fifo_data_i        (fifo_data_i)
    );

    // Single-port 32x16 FIFO: one command per cycle, registered read data.
    logic [31:0] fmem [16];
    logic [3:0]  wp = '0;
    logic [3:0]  rp = '0;
    logic [4:0]  fcnt = '0;
    logic [31:0] frd_q = '0;

    assign fifo_full_i  = (fcnt == 5'd16);
    assign fifo_empty_i = (fcnt == 5'd0);
    assign fifo_data_i  = frd_q;

    always @(posedge clk) begin
        if (!reset_ni) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else if (fifo_v_o && fifo_enq_not_deq_o && fcnt != 5'd16) begin
            fmem[wp] <= fifo_data_o;
            wp       <= wp + 4'd1;
            fcnt     <= fcnt + 5'd1;
        end else if (fifo_v_o && !fifo_enq_not_deq_o && fcnt != 5'd0) begin
            frd_q <= fmem[rp];
            rp    <= rp + 4'd1;
            fcnt  <= fcnt - 5'd1;
        end
    end

    // Reference: words accepted but not yet delivered, plus the arbitration rules.
    logic [31:0] exp_q[$];
    bit          inflight_m = 1'b0;
    bit          prio_deq_m = 1'b0;

    always @(negedge clk) begin
        int  obuf_m;
        bit  deq_ok_m;
        bit  enq_ok_m;
        bit  exp_ready;
        bit  exp_enq;
        bit  exp_deq;
        logic [31:0] w;
        if (!reset_ni) begin
            n_vec++;
            if (up_ready_o !== 1'b0 || fifo_v_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_gate: up_ready_o=%b fifo_v_o=%b, want 0/0 t=%0t", up_ready_o, fifo_v_o, $time);
            end
            exp_q.delete();
            inflight_m = 1'b0;
            prio_deq_m = 1'b0;
        end else begin
            obuf_m    = exp_q.size() - int'(fcnt) - int'(inflight_m);
            deq_ok_m  = (fcnt != 0) && (obuf_m + int'(inflight_m) < 2);
            enq_ok_m  = (fcnt != 16);
            exp_ready = enq_ok_m && !(deq_ok_m && prio_deq_m);
            exp_enq   = up_v_i && exp_ready;
            exp_deq   = deq_ok_m && !exp_enq;

            n_vec++;
            if (obuf_m < 0 || obuf_m > 2) begin
                n_err++;
                $display("FAIL obuf_occupancy: got %0d want 0..2 t=%0t", obuf_m, $time);
            end
            n_vec++;
            if (up_ready_o !== exp_ready) begin
                n_err++;
                $display("FAIL up_ready: got %b want %b t=%0t", up_ready_o, exp_ready, $time);
            end
            n_vec++;
            if (fifo_v_o !== (exp_enq || exp_deq) || fifo_enq_not_deq_o !== exp_enq) begin
                n_err++;
                $display("FAIL fifo_cmd: got v=%b enq=%b want v=%b enq=%b t=%0t",
                         fifo_v_o, fifo_enq_not_deq_o, exp_enq || exp_deq, exp_enq, $time);
            end
            n_vec++;
            if (fifo_v_o && !fifo_enq_not_deq_o && fcnt == 0) begin
                n_err++;
                $display("FAIL deq_when_empty: got deq with fifo empty, want none t=%0t", $time);
            end
            if (exp_enq) begin
                n_vec++;
                if (fifo_data_o !== up_data_i) begin
                    n_err++;
                    $display("FAIL fifo_data: got %h want %h t=%0t", fifo_data_o, up_data_i, $time);
                end
            end
            n_vec++;
            if (dn_v_o !== (obuf_m > 0)) begin
                n_err++;
                $display("FAIL dn_v: got %b want %b t=%0t", dn_v_o, obuf_m > 0, $time);
            end

            if (dn_v_o === 1'b1 && dn_ready_i) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL dn_data: got %h want no word t=%0t", dn_data_o, $time);
                end else begin
                    w = exp_q.pop_front();
                    if (dn_data_o !== w) begin
                        n_err++;
                        $display("FAIL dn_data: got %h want %h t=%0t", dn_data_o, w, $time);
                    end
                end
                n_deliv++;
            end
            if (up_v_i && up_ready_o === 1'b1) exp_q.push_back(up_data_i);

            inflight_m = (fifo_v_o === 1'b1) && (fifo_enq_not_deq_o === 1'b0);
            if (enq_ok_m && deq_ok_m) prio_deq_m = !prio_deq_m;
        end
    end

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        up_v_i     = v;
        up_data_i  = d;
        dn_ready_i = r;
    endtask

    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b0, '0, 1'b1);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d words left want 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_ni   = 1'b0;
        up_v_i     = 1'b1;
        dn_ready_i = 1'b1;
        up_data_i  = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (up_ready_o !== 1'b0 || fifo_v_o !== 1'b0) begin
                n_err++;
                $display("FAIL test_reset_gate: up_ready_o=%b fifo_v_o=%b want 0/0", up_ready_o, fifo_v_o);
            end
            if (i > 0) begin
                n_vec++;
                if (dn_v_o !== 1'b0) begin
                    n_err++;
                    $display("FAIL test_reset_dn_v: got %b want 0", dn_v_o);
                end
            end
        end
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        up_v_i   = 1'b0;
    endtask

    task automatic test_single_word();
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        n_vec++;
        if (up_ready_o !== 1'b1 || fifo_v_o !== 1'b1 || fifo_enq_not_deq_o !== 1'b1) begin
            n_err++;
            $display("FAIL single_enq: got rdy=%b v=%b enq=%b want 1/1/1", up_ready_o, fifo_v_o, fifo_enq_not_deq_o);
        end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        n_vec++;
        if (fifo_v_o !== 1'b1 || fifo_enq_not_deq_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_deq: got v=%b enq=%b want 1/0", fifo_v_o, fifo_enq_not_deq_o);
        end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        n_vec++;
        if (dn_v_o !== 1'b0 || fifo_v_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_n2: got dn_v=%b fifo_v=%b want 0/0", dn_v_o, fifo_v_o);
        end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        n_vec++;
        if (dn_v_o !== 1'b1 || dn_data_o !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL single_n3: got v=%b data=%h want 1/deadbeef", dn_v_o, dn_data_o);
        end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        n_vec++;
        if (dn_v_o !== 1'b0 || fifo_v_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_n4: got dn_v=%b fifo_v=%b want 0/0", dn_v_o, fifo_v_o);
        end
    endtask

    task automatic test_fill();
        int idx = 0;
        int got = 0;
        for (int c = 0; c < 100; c++) begin
            drive(1'b1, 32'(idx), 1'b0);
            @(negedge clk);
            if (up_ready_o === 1'b1) idx++;
        end
        n_vec++;
        if (idx != 18 || up_ready_o !== 1'b0 || fifo_full_i !== 1'b1) begin
            n_err++;
            $display("FAIL fill_capacity: got %0d words rdy=%b full=%b want 18/0/1", idx, up_ready_o, fifo_full_i);
        end
        for (int c = 0; c < 200 && got < 18; c++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            if (dn_v_o === 1'b1) begin
                n_vec++;
                if (dn_data_o !== 32'(got)) begin
                    n_err++;
                    $display("FAIL fill_order: got %h want %h", dn_data_o, 32'(got));
                end
                got++;
            end
        end
        n_vec++;
        if (got != 18) begin
            n_err++;
            $display("FAIL fill_drain: got %0d words want 18", got);
        end
        drain(10);
    endtask

    task automatic test_contention();
        bit have_last = 1'b0;
        bit last_enq = 1'b0;
        int n_enq = 0;
        int n_deq = 0;
        for (int c = 0; c < 50 && fcnt < 4; c++) begin
            drive(1'b1, $urandom, 1'b0);
            @(negedge clk);
        end
        for (int c = 0; c < 40; c++) begin
            drive(1'b1, $urandom, 1'b1);
            @(negedge clk);
            if (c >= 8) begin
                n_vec++;
                if (fifo_v_o !== 1'b1 || (have_last && fifo_enq_not_deq_o === last_enq)) begin
                    n_err++;
                    $display("FAIL contention_alt: got v=%b enq=%b want v=1 enq=%b", fifo_v_o, fifo_enq_not_deq_o, !last_enq);
                end
                have_last = 1'b1;
                last_enq  = fifo_enq_not_deq_o;
                if (fifo_enq_not_deq_o === 1'b1) n_enq++;
                else n_deq++;
            end
        end
        n_vec++;
        if (n_enq < 10 || n_deq < 10) begin
            n_err++;
            $display("FAIL contention_starve: got enq=%0d deq=%0d want both >=10", n_enq, n_deq);
        end
        drain(40);
    endtask

    task automatic test_random();
        int n_acc = 0;
        int start_deliv;
        drive(1'b0, '0, 1'b0);
        start_deliv = n_deliv;
        for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            if (up_v_i && up_ready_o === 1'b1) n_acc++;
        end
        n_vec++;
        if (n_acc != 1000) begin
            n_err++;
            $display("FAIL random_budget: got %0d accepted want 1000", n_acc);
        end
        drain(60);
        n_vec++;
        if (n_deliv - start_deliv != n_acc) begin
            n_err++;
            $display("FAIL random_count: got %0d delivered want %0d", n_deliv - start_deliv, n_acc);
        end
    endtask

    task automatic test_reset_mid_read();
        bit got = 1'b0;
        drive(1'b1, 32'hA5A50001, 1'b1);
        @(negedge clk);
        n_vec++;
        if (fifo_v_o !== 1'b1 || fifo_enq_not_deq_o !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_enq: got v=%b enq=%b want 1/1", fifo_v_o, fifo_enq_not_deq_o);
        end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        n_vec++;
        if (fifo_v_o !== 1'b1 || fifo_enq_not_deq_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_deq: got v=%b enq=%b want 1/0", fifo_v_o, fifo_enq_not_deq_o);
        end
        @(posedge clk);
        #1;
        reset_ni = 1'b0;
        @(posedge clk);
        #1;
        reset_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) drive(1'b0, '0, 1'b1);
            @(negedge clk);
            n_vec++;
            if (dn_v_o !== 1'b0) begin
                n_err++;
                $display("FAIL midrst_discard: got dn_v=%b data=%h want 0", dn_v_o, dn_data_o);
            end
        end
        drive(1'b1, 32'h1, 1'b1);
        @(negedge clk);
        n_vec++;
        if (up_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_accept: got rdy=%b want 1", up_ready_o);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            if (dn_v_o === 1'b1) begin
                got = 1'b1;
                n_vec++;
                if (dn_data_o !== 32'h1) begin
                    n_err++;
                    $display("FAIL midrst_first: got %h want 00000001", dn_data_o);
                end
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL midrst_timeout: got no word want 00000001");
        end
    endtask

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout want completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_contention();
        test_random();
        test_reset_mid_read();
        drive(1'b0, '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_1rw_stream_adapter.md
Name: fifo_1rw_stream_adapter

Overview:
Upstream/downstream shim for the single-port 32-bit x 16 FIFO wrapper, whose FIFO performs exactly one operation per cycle (enqueue or dequeue) on one shared v_i/enq_not_deq_i command.
This block converts a producer valid/ready stream and a consumer valid/ready stream into that command interface. It arbitrates between enqueue and dequeue and captures the FIFO's registered read data into a 2-entry output buffer.
It sits between the producer, the FIFO wrapper and the consumer; the top level drives the FIFO's reset_i = ~reset_ni.

Parameters:
width_p, 32, data word width; must match the FIFO width.
obuf_els_p, 2, output buffer depth; fixed at 2 and not overridable.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_ni  in  1  reset, synchronous, active-low
up_v_i  in  1  producer word valid
up_data_i  in  width_p  producer word
up_ready_o  out  1  adapter accepts up_data_i this cycle
dn_v_o  out  1  consumer word valid
dn_data_o  out  width_p  consumer word (oldest buffered)
dn_ready_i  in  1  consumer takes dn_data_o this cycle
fifo_v_o  out  1  to FIFO v_i
fifo_enq_not_deq_o  out  1  to FIFO enq_not_deq_i (1=enq, 0=deq)
fifo_data_o  out  width_p  to FIFO data_i (= up_data_i)
fifo_full_i  in  1  from FIFO full_o
fifo_empty_i  in  1  from FIFO empty_o
fifo_data_i  in  width_p  from FIFO data_o; valid the cycle after a deq command

Behaviour:
- Reset (reset_ni=0 at a clock edge) clears state:
  - output buffer empty, in-flight flag 0, priority = ENQ
  - dn_v_o=0 from the following cycle
  - while reset_ni=0: up_ready_o=0 and fifo_v_o=0, gated combinationally.
- Reset mid-operation discards any in-flight read and all buffered words. The FIFO is reset in the same cycle.
- Dequeue eligibility: deq_ok = !fifo_empty_i && (obuf_count + inflight) < 2. This reserves buffer space for every read issued.
- Enqueue eligibility: enq_ok = !fifo_full_i.
- Arbitration is per cycle:
  - Only one eligible side: it wins.
  - Both eligible (contended): the side named by prio wins. Prio flips after every contended cycle; it is unchanged otherwise.
  - Enqueue eligibility does not depend on up_v_i. An idle producer still takes the grant when prio=ENQ; the grant is simply unused that cycle.
- up_ready_o = enq_ok && !(deq_ok && prio==DEQ). This is combinational from FIFO flags and state only, never from up_v_i.
- Enqueue fire = up_v_i && up_ready_o:
  - fifo_v_o=1, fifo_enq_not_deq_o=1
  - fifo_data_o is up_data_i, passed through unregistered.
- Dequeue fire = deq_ok && !enqueue fire:
  - fifo_v_o=1, fifo_enq_not_deq_o=0
  - inflight is set for the next cycle.
- When inflight=1, fifo_data_i is written into the buffer tail at that cycle's edge.
- fifo_v_o=0 when neither side fires. fifo_enq_not_deq_o is don't-care when fifo_v_o=0 and is driven 0.
- Output buffer:
  - dn_v_o = (obuf_count != 0); dn_data_o = head entry, registered.
  - Pop when dn_v_o && dn_ready_i. Pop and push in the same cycle are both honoured.
  - Count range 0..2; overflow is impossible by construction.
- Latency and throughput:
  - A word accepted in cycle N, with an empty FIFO, empty buffer, dn_ready_i=1 and no contention, appears on dn_v_o exactly in cycle N+3 (deq at N+1, data at N+2, registered).
  - Sustained throughput is 1 word per 2 cycles under full contention.
- Ordering: strict FIFO order producer to consumer; no loss, no duplication.
- Capacity: with dn_ready_i held 0, total words accepted = 16 + 2 = 18.

Decomposition:
- Package fifo_adapter_pkg: width constant (32), obuf depth constant (2), prio enum {PRIO_ENQ, PRIO_DEQ}.
- One sub-module, fifo_adapter_obuf: 2-entry register buffer with push/pop, count, head output, synchronous active-low clear.
- Arbiter and in-flight tracking stay in the top module.

Test Plan:
- Reset: reset_ni=0 for 3 cycles with up_v_i=1, dn_ready_i=1 -> up_ready_o=0, fifo_v_o=0 throughout; dn_v_o=0 on the cycle after the first reset edge.
- Single word: 0xDEADBEEF accepted at cycle N, dn_ready_i=1 -> enq at N, deq at N+1; dn_v_o=1 with 0xDEADBEEF at N+3 for exactly one cycle; then idle.
- Fill: dn_ready_i=0, push 0..N continuously -> exactly 18 words (0..17) accepted, then up_ready_o=0 and fifo_full_i=1. Raise dn_ready_i -> 0..17 delivered in order.
- Contention: FIFO preloaded with 4 words, up_v_i=1 and dn_ready_i=1 constantly -> fifo_enq_not_deq_o alternates 1,0,1,0 on consecutive fifo_v_o cycles; neither side starves.
- Random stress: 1000 random words, random up_v_i and dn_ready_i at 50% -> consumer sequence equals producer sequence; obuf count never exceeds 2; no deq issued while fifo_empty_i=1.
- Reset mid-read: assert reset_ni=0 in the cycle after a deq is issued -> no word is delivered from that read; dn_v_o=0 after the reset edge; the first post-reset push of 0x1 is delivered as 0x1.
